// File: rtl/simon_pkg.sv
// Shared SIMON definitions: z sequences, FSM states, N-bit rotates, round function, key constant.
// Functions work on 64-bit containers with an explicit word size; callers truncate to N bits.
package simon_pkg;

  // Element 0 of each sequence is the MSB, i.e. the leftmost symbol as published.
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

  typedef enum logic [2:0] {OCIOSO, EXPANDE, PRONTO, RODADA, SAIDA} estado_t;

  function automatic logic [63:0] mascara(int n);
    return (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [63:0] rol(logic [63:0] x, int j, int n);
    logic [63:0] v;
    v = x & mascara(n);
    return ((v << j) | (v >> (n - j))) & mascara(n);
  endfunction

  function automatic logic [63:0] ror(logic [63:0] x, int j, int n);
    return rol(x, n - j, n);
  endfunction

  function automatic logic [63:0] f_rodada(logic [63:0] x, int n);
    return (rol(x, 1, n) & rol(x, 8, n)) ^ rol(x, 2, n);
  endfunction

  // 2^n - 4: all ones except the two low bits.
  function automatic logic [63:0] constante_c(int n);
    return mascara(n) & ~64'd3;
  endfunction

  function automatic logic zbit_de(int sel, logic [5:0] idx);
    case (sel)
      0:       return Z0[6'd61 - idx];
      1:       return Z1[6'd61 - idx];
      2:       return Z2[6'd61 - idx];
      3:       return Z3[6'd61 - idx];
      default: return Z4[6'd61 - idx];
    endcase
  endfunction

endpackage

// File: rtl/simon_cifra_iterativa_if.sv
// Host-side bundle for the SIMON core: key and block inputs, result output, all valid/ready.
interface simon_cifra_iterativa_if #(parameter int N = 64, parameter int M = 2);
  logic           chave_valida;
  logic           chave_pronta;
  logic [N*M-1:0] chave;
  logic           bloco_valido;
  logic           bloco_pronto;
  logic           modo;
  logic [2*N-1:0] texto;
  logic           saida_valida;
  logic           saida_pronta;
  logic [2*N-1:0] criptografia;
  logic           chave_carregada;

  modport master (
    output chave_valida, chave, bloco_valido, modo, texto, saida_pronta,
    input  chave_pronta, bloco_pronto, saida_valida, criptografia, chave_carregada
  );

  modport slave (
    input  chave_valida, chave, bloco_valido, modo, texto, saida_pronta,
    output chave_pronta, bloco_pronto, saida_valida, criptografia, chave_carregada
  );
endinterface

// File: rtl/simon_passo_chave.sv
// Combinational key-schedule step: produces k[i+M] from the window k[i..i+M-1] and the z bit.
module simon_passo_chave
  import simon_pkg::*;
#(
  parameter int N = 64,
  parameter int M = 2
) (
  input  logic [N*M-1:0] janela,
  input  logic           zbit,
  output logic [N-1:0]   novo
);
  logic [N-1:0] tmp;

  always_comb begin
    tmp = N'(ror(64'(janela[N*M-1 -: N]), 3, N));
    if (M == 4) tmp = tmp ^ janela[2*N-1 -: N];
    tmp  = tmp ^ N'(ror(64'(tmp), 1, N));
    novo = N'(constante_c(N)) ^ janela[N-1:0] ^ tmp ^ {{(N-1){1'b0}}, zbit};
  end
endmodule

// File: rtl/simon_cifra_iterativa.sv
// Iterative SIMON: key expands once into a round-key buffer (T-M cycles), then one block at a time, T cycles each.
// Result is held until accepted; no new key or block is taken while a result waits.
module simon_cifra_iterativa
  import simon_pkg::*;
#(
  parameter int N    = 64,
  parameter int M    = 2,
  parameter int T    = 68,
  parameter int ZSEL = 2
) (
  input logic clk,
  input logic rst,
  simon_cifra_iterativa_if.slave bus
);
  localparam int CW = $clog2(T);

  if (!(N == 16 || N == 24 || N == 32 || N == 48 || N == 64)) begin : g_erro_n
    $error("simon_cifra_iterativa: illegal N");
  end
  if (!(M >= 2 && M <= 4) || T < M + 1 || ZSEL < 0 || ZSEL > 4) begin : g_erro_p
    $error("simon_cifra_iterativa: illegal M, T or ZSEL");
  end

  estado_t        estado;
  logic [N-1:0]   rk [T];
  logic [N*M-1:0] janela;
  logic [CW-1:0]  cont;
  logic [5:0]     zi;
  logic [N-1:0]   x, y, novo, kr, fx, xn, yn;
  logic [CW-1:0]  idx;
  logic           decifra;
  logic           saida_valida_r, chave_carregada_r;
  logic [2*N-1:0] criptografia_r;

  simon_passo_chave #(.N(N), .M(M)) u_passo (
    .janela (janela),
    .zbit   (zbit_de(ZSEL, zi)),
    .novo   (novo)
  );

  // Decryption walks the same buffer backwards.
  always_comb begin
    idx = decifra ? (CW'(T - 1) - cont) : cont;
    kr  = rk[idx];
    fx  = N'(f_rodada(64'(decifra ? y : x), N));
    if (decifra) begin
      xn = y;
      yn = x ^ fx ^ kr;
    end else begin
      xn = y ^ fx ^ kr;
      yn = x;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado            <= OCIOSO;
      cont              <= '0;
      zi                <= '0;
      saida_valida_r    <= 1'b0;
      criptografia_r    <= '0;
      chave_carregada_r <= 1'b0;
    end else begin
      case (estado)
        OCIOSO, PRONTO: begin
          if (bus.chave_valida) begin
            for (int j = 0; j < M; j++) rk[CW'(j)] <= bus.chave[j*N +: N];
            janela            <= bus.chave;
            cont              <= '0;
            zi                <= '0;
            chave_carregada_r <= 1'b0;
            estado            <= EXPANDE;
          end else if (estado == PRONTO && bus.bloco_valido) begin
            x       <= bus.texto[2*N-1:N];
            y       <= bus.texto[N-1:0];
            decifra <= bus.modo;
            cont    <= '0;
            estado  <= RODADA;
          end
        end
        EXPANDE: begin
          rk[cont + CW'(M)] <= novo;
          janela            <= {novo, janela[N*M-1:N]};
          zi                <= (zi == 6'd61) ? 6'd0 : zi + 6'd1;
          if (cont == CW'(T - M - 1)) begin
            cont              <= '0;
            chave_carregada_r <= 1'b1;
            estado            <= PRONTO;
          end else begin
            cont <= cont + 1'b1;
          end
        end
        RODADA: begin
          x <= xn;
          y <= yn;
          if (cont == CW'(T - 1)) begin
            cont           <= '0;
            criptografia_r <= {xn, yn};
            saida_valida_r <= 1'b1;
            estado         <= SAIDA;
          end else begin
            cont <= cont + 1'b1;
          end
        end
        SAIDA: begin
          if (bus.saida_pronta) begin
            saida_valida_r <= 1'b0;
            estado         <= PRONTO;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign bus.chave_pronta    = (estado == OCIOSO) || (estado == PRONTO);
  assign bus.bloco_pronto    = (estado == PRONTO) && !bus.chave_valida;
  assign bus.saida_valida    = saida_valida_r;
  assign bus.criptografia    = criptografia_r;
  assign bus.chave_carregada = chave_carregada_r;
endmodule

// File: tb/tb_simon_cifra_iterativa.sv
// Bench for the iterative SIMON core: known-answer vectors for three configurations plus random traffic vs a model.
module tb_simon_cifra_iterativa;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  localparam logic [61:0] ZT [5] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111};

  simon_cifra_iterativa_if #(.N(64), .M(2)) if0 ();
  simon_cifra_iterativa_if #(.N(16), .M(4)) if1 ();
  simon_cifra_iterativa_if #(.N(32), .M(4)) if2 ();

  simon_cifra_iterativa #(.N(64), .M(2), .T(68), .ZSEL(2)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  simon_cifra_iterativa #(.N(16), .M(4), .T(32), .ZSEL(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  simon_cifra_iterativa #(.N(32), .M(4), .T(44), .ZSEL(3)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  int testes = 0;
  int falhas = 0;

  task automatic verifica(input string tag, input logic [127:0] obs, input logic [127:0] esp);
    testes++;
    if (obs !== esp) begin
      falhas++;
      $display("FAIL %s: observed %h expected %h", tag, obs, esp);
    end
  endtask

  function automatic logic [63:0] msk(int n);
    if (n == 64) return {64{1'b1}};
    return (64'd1 << n) - 64'd1;
  endfunction
  function automatic logic [63:0] rl(logic [63:0] v, int j, int n);
    return ((v << j) | (v >> (n - j))) & msk(n);
  endfunction
  function automatic logic [63:0] rr(logic [63:0] v, int j, int n);
    return ((v >> j) | (v << (n - j))) & msk(n);
  endfunction

  // Full key schedule then T rounds, straight from the cipher definition.
  function automatic logic [127:0] modelo(logic [255:0] key, int n, int m, int t, int zs,
                                           logic [127:0] txt, bit dec);
    logic [63:0] k [0:127];
    logic [63:0] a, b, tmp, fv;
    logic [61:0] zz;
    zz = ZT[zs];
    for (int i = 0; i < m; i++) k[i] = 64'(key >> (i * n)) & msk(n);
    for (int i = 0; i < t - m; i++) begin
      tmp = rr(k[i+m-1], 3, n);
      if (m == 4) tmp = tmp ^ k[i+1];
      tmp = tmp ^ rr(tmp, 1, n);
      k[i+m] = (msk(n) - 64'd3) ^ 64'(zz[61 - (i % 62)]) ^ k[i] ^ tmp;
    end
    a = 64'(txt >> n) & msk(n);
    b = 64'(txt) & msk(n);
    for (int r = 0; r < t; r++) begin
      if (!dec) begin
        fv = (rl(a, 1, n) & rl(a, 8, n)) ^ rl(a, 2, n);
        tmp = a; a = b ^ fv ^ k[r]; b = tmp;
      end else begin
        fv = (rl(b, 1, n) & rl(b, 8, n)) ^ rl(b, 2, n);
        tmp = b; b = a ^ fv ^ k[t-1-r]; a = tmp;
      end
    end
    return (128'(a) << n) | 128'(b);
  endfunction

  task automatic carrega0(input logic [127:0] k, output int ciclos);
    int w = 0;
    if0.chave = k;
    if0.chave_valida = 1'b1;
    while (!if0.chave_pronta && w < 200) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    if0.chave_valida = 1'b0;
    ciclos = 0;
    while (!if0.chave_carregada && ciclos < 200) begin @(posedge clk); #1; ciclos++; end
  endtask

  task automatic cifra0(input logic [127:0] txt, input logic md, output logic [127:0] res,
                        output int lat);
    int w = 0;
    if0.texto = txt;
    if0.modo = md;
    if0.bloco_valido = 1'b1;
    while (!if0.bloco_pronto && w < 200) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    if0.bloco_valido = 1'b0;
    lat = 0;
    while (!if0.saida_valida && lat < 200) begin @(posedge clk); #1; lat++; end
    res = if0.criptografia;
    if0.saida_pronta = 1'b1;
    @(posedge clk); #1;
    if0.saida_pronta = 1'b0;
  endtask

  logic [127:0] key, txt, res, esp;
  logic [255:0] key256;
  logic         md;
  int           n, lat;
  bit           marcou;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    {if0.chave_valida, if0.bloco_valido, if0.modo, if0.saida_pronta} = '0;
    {if1.chave_valida, if1.bloco_valido, if1.modo, if1.saida_pronta} = '0;
    {if2.chave_valida, if2.bloco_valido, if2.modo, if2.saida_pronta} = '0;
    if0.chave = '0; if0.texto = '0;
    if1.chave = '0; if1.texto = '0;
    if2.chave = '0; if2.texto = '0;
    repeat (3) @(posedge clk);
    #1;
    verifica("rst_chave_pronta", if0.chave_pronta, 1'b1);
    verifica("rst_bloco_pronto", if0.bloco_pronto, 1'b0);
    verifica("rst_saida_valida", if0.saida_valida, 1'b0);
    verifica("rst_criptografia", if0.criptografia, 128'd0);
    verifica("rst_chave_carregada", if0.chave_carregada, 1'b0);
    rst = 1'b0;

    // SIMON32/64
    verifica("s32_chave_pronta", if1.chave_pronta, 1'b1);
    if1.chave = 64'h1918_1110_0908_0100;
    if1.chave_valida = 1'b1;
    @(posedge clk); #1;
    if1.chave_valida = 1'b0;
    n = 0;
    while (!if1.chave_carregada && n < 200) begin @(posedge clk); #1; n++; end
    verifica("s32_expansao", n, 28);
    if1.texto = 32'h6565_6877;
    if1.bloco_valido = 1'b1;
    @(posedge clk); #1;
    if1.bloco_valido = 1'b0;
    n = 0;
    while (!if1.saida_valida && n < 200) begin @(posedge clk); #1; n++; end
    verifica("s32_latencia", n, 32);
    verifica("s32_kat", if1.criptografia, 32'hc69b_e9bb);
    if1.saida_pronta = 1'b1;
    @(posedge clk); #1;
    if1.saida_pronta = 1'b0;

    // SIMON64/128, encrypt then decrypt under the same expanded key
    if2.chave = 128'h1b1a1918_13121110_0b0a0908_03020100;
    if2.chave_valida = 1'b1;
    @(posedge clk); #1;
    if2.chave_valida = 1'b0;
    n = 0;
    while (!if2.chave_carregada && n < 200) begin @(posedge clk); #1; n++; end
    verifica("s64_expansao", n, 40);
    for (int p = 0; p < 2; p++) begin
      if2.texto = (p == 0) ? 64'h656b696c_20646e75 : 64'h44c8fc20_b9dfa07a;
      if2.modo = (p == 1);
      if2.bloco_valido = 1'b1;
      @(posedge clk); #1;
      if2.bloco_valido = 1'b0;
      n = 0;
      while (!if2.saida_valida && n < 200) begin @(posedge clk); #1; n++; end
      verifica("s64_latencia", n, 44);
      verifica(p == 0 ? "s64_cifra" : "s64_decifra", if2.criptografia,
               p == 0 ? 64'h44c8fc20_b9dfa07a : 64'h656b696c_20646e75);
      if2.saida_pronta = 1'b1;
      @(posedge clk); #1;
      if2.saida_pronta = 1'b0;
    end

    // SIMON128/128 known answer
    carrega0(128'h0f0e0d0c0b0a0908_0706050403020100, n);
    verifica("s128_expansao", n, 66);
    verifica("s128_carregada", if0.chave_carregada, 1'b1);
    cifra0(128'h6373656420737265_6c6c657661727420, 1'b0, res, lat);
    verifica("s128_latencia", lat, 68);
    verifica("s128_kat", res, 128'h49681b1e1e54fe3f_65aa832af84e0bbc);
    key = 128'h0f0e0d0c0b0a0908_0706050403020100;

    // Random keys, blocks and directions
    for (int it = 0; it < 6; it++) begin
      if (it % 2 == 0) begin
        key = {$urandom, $urandom, $urandom, $urandom};
        carrega0(key, n);
        verifica("rnd_expansao", n, 66);
      end
      txt = {$urandom, $urandom, $urandom, $urandom};
      md = 1'($urandom_range(0, 1));
      key256 = 256'(key);
      cifra0(txt, md, res, lat);
      verifica("rnd_latencia", lat, 68);
      verifica(md ? "rnd_decifra" : "rnd_cifra", res, modelo(key256, 64, 2, 68, 2, txt, md));
    end

    // Backpressure: result must hold while the sink stalls
    txt = {$urandom, $urandom, $urandom, $urandom};
    esp = modelo(256'(key), 64, 2, 68, 2, txt, 1'b0);
    if0.texto = txt; if0.modo = 1'b0; if0.bloco_valido = 1'b1;
    @(posedge clk); #1;
    if0.bloco_valido = 1'b0;
    n = 0;
    while (!if0.saida_valida && n < 200) begin @(posedge clk); #1; n++; end
    verifica("bp_latencia", n, 68);
    for (int c = 0; c < 10; c++) begin
      verifica("bp_estavel", if0.criptografia, esp);
      verifica("bp_valida", if0.saida_valida, 1'b1);
      verifica("bp_bloco_pronto", if0.bloco_pronto, 1'b0);
      verifica("bp_chave_pronta", if0.chave_pronta, 1'b0);
      @(posedge clk); #1;
    end
    if0.saida_pronta = 1'b1;
    @(posedge clk); #1;
    if0.saida_pronta = 1'b0;
    verifica("bp_solta_valida", if0.saida_valida, 1'b0);
    verifica("bp_solta_chave_pronta", if0.chave_pronta, 1'b1);
    verifica("bp_solta_bloco_pronto", if0.bloco_pronto, 1'b1);

    // Reset during round 30 aborts and invalidates the key
    if0.texto = txt; if0.bloco_valido = 1'b1;
    @(posedge clk); #1;
    if0.bloco_valido = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    verifica("mid_rst_saida_valida", if0.saida_valida, 1'b0);
    verifica("mid_rst_carregada", if0.chave_carregada, 1'b0);
    verifica("mid_rst_chave_pronta", if0.chave_pronta, 1'b1);
    verifica("mid_rst_bloco_pronto", if0.bloco_pronto, 1'b0);
    if0.bloco_valido = 1'b1;
    marcou = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (if0.bloco_pronto || if0.saida_valida) marcou = 1'b1;
      @(posedge clk); #1;
    end
    if0.bloco_valido = 1'b0;
    verifica("mid_rst_bloco_ignorado", marcou, 1'b0);

    // Collision: key and block offered together in PRONTO
    carrega0(key, n);
    verifica("col_expansao1", n, 66);
    key = {$urandom, $urandom, $urandom, $urandom};
    txt = {$urandom, $urandom, $urandom, $urandom};
    if0.chave = key; if0.chave_valida = 1'b1;
    if0.texto = txt; if0.modo = 1'b0; if0.bloco_valido = 1'b1;
    #1;
    verifica("col_bloco_pronto", if0.bloco_pronto, 1'b0);
    @(posedge clk); #1;
    if0.chave_valida = 1'b0;
    verifica("col_carregada_baixa", if0.chave_carregada, 1'b0);
    n = 0;
    marcou = 1'b0;
    while (!if0.chave_carregada && n < 200) begin
      if (if0.bloco_pronto) marcou = 1'b1;
      @(posedge clk); #1; n++;
    end
    verifica("col_expansao2", n, 66);
    verifica("col_bloco_durante_exp", marcou, 1'b0);
    verifica("col_bloco_pronto_apos", if0.bloco_pronto, 1'b1);
    @(posedge clk); #1;
    if0.bloco_valido = 1'b0;
    n = 0;
    while (!if0.saida_valida && n < 200) begin @(posedge clk); #1; n++; end
    verifica("col_latencia", n, 68);
    verifica("col_nova_chave", if0.criptografia, modelo(256'(key), 64, 2, 68, 2, txt, 1'b0));
    if0.saida_pronta = 1'b1;
    @(posedge clk); #1;
    if0.saida_pronta = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end
endmodule

// File: doc/simon_cifra_iterativa.md
Name: simon_cifra_iterativa

Overview:
Parametrised iterative SIMON block cipher core, n-bit words, m-word key, T rounds, computing one round per clock. A loaded key is expanded once into an internal round-key buffer. Blocks are then encrypted or decrypted against that buffer, one block in flight at a time. Input and output use valid/ready handshakes, so the core sits between the host data path and the payload buffer.

Parameters:
N, 64, word size n in bits; legal values 16, 24, 32, 48, 64
M, 2, key words m; legal values 2, 3, 4
T, 68, rounds; must satisfy T >= M+1
ZSEL, 2, index 0..4 of the z constant sequence

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
chave_valida  in  1  key offered
chave_pronta  out  1  core accepts key
chave  in  N*M  key; chave[N-1:0]=k0, top word = k(M-1)
bloco_valido  in  1  block offered
bloco_pronto  out  1  core accepts block
modo  in  1  0=encrypt, 1=decrypt; sampled with block
texto  in  2N  input block; upper word = x, lower word = y
saida_valida  out  1  result available
saida_pronta  in  1  sink accepts result
criptografia  out  2N  result; upper word = x, lower word = y
chave_carregada  out  1  round-key buffer valid

Behaviour:
- Only one clock is used. rst is synchronous and active-high. All rotations are circular on N bits. Sj is a left rotate by j; S-j is a right rotate by j.
- Round function: f(x) = (S1 x & S8 x) ^ S2 x.
- Encrypt round with key k: (x,y) <- (y ^ f(x) ^ k, x).
- Decrypt round with key k: (x,y) <- (y, x ^ f(y) ^ k).
- Key schedule: c = 2^N - 4.
  - M=2: tmp = S-3 k[i+1].
  - M=3: tmp = S-3 k[i+2].
  - M=4: tmp = S-3 k[i+3] ^ k[i+1].
  - In all cases: tmp = tmp ^ S-1 tmp; k[i+M] = c ^ zbit ^ k[i] ^ tmp.
  - zbit = element (i mod 62) of sequence z[ZSEL], with element 0 being the leftmost symbol as published.
- States: OCIOSO, EXPANDE, PRONTO, RODADA, SAIDA.
- Reset values: state=OCIOSO; chave_pronta=1; bloco_pronto=0; saida_valida=0; criptografia=0; chave_carregada=0; round counter=0.
- Handshakes: a transfer occurs on an edge where valid&ready. Once asserted, saida_valida and criptografia stay stable until accepted.
- Key load (accepted in OCIOSO or PRONTO):
  - k0..k(M-1) are written at the accept edge E; chave_carregada drops to 0.
  - State goes to EXPANDE. k[i] for i>=M is written at edge E+(i-M+1).
  - After k[T-1] is written at edge E+T-M, the state goes to PRONTO and chave_carregada=1.
- chave_pronta = state in {OCIOSO, PRONTO}.
- bloco_pronto = (state==PRONTO) & !chave_valida. A simultaneous key offer wins; the block is not accepted.
- Block (accepted at edge A):
  - x, y and modo are registered, counter r=0, state goes to RODADA.
  - At edges A+1..A+T the core applies round r, using k[r] for encrypt or k[T-1-r] for decrypt, then increments r.
  - At edge A+T the state goes to SAIDA and saida_valida=1. Block latency is T cycles.
- Output: on saida_valida&saida_pronta, saida_valida goes to 0 and the state returns to PRONTO. The key buffer is retained for subsequent blocks.
- Blocks are never pipelined or overlapped. bloco_pronto stays low during RODADA and SAIDA.
- rst asserted in any state, including mid-EXPANDE or mid-RODADA, aborts the operation. Reset values apply on the next edge and the key is invalidated; a new key is required before any block.
- In OCIOSO, bloco_valido is ignored.
- T > 62: the z index wraps modulo 62.
- Illegal parameter values fail elaboration through an assertion.

Decomposition:
- Package simon_pkg holds:
  - the five 62-bit z constants (z0..z4);
  - the state enum;
  - functions for the round function f and the N-bit rotates;
  - a function returning c for N.
- Sub-module simon_passo_chave: combinational next-key-word generator. Inputs are the M-word window and zbit; output is k[i+M]. The core instantiates it once.

Test Plan:
- Default params (SIMON128/128), encrypt:
  - key 0f0e0d0c0b0a0908_0706050403020100, texto 6373656420737265_6c6c657661727420;
  - required criptografia 49681b1e1e54fe3f_65aa832af84e0bbc;
  - saida_valida rises exactly 68 cycles after block accept; expansion takes 66 cycles.
- N=16, M=4, T=32, ZSEL=0 (SIMON32/64):
  - key 1918_1110_0908_0100, texto 6565_6877 -> criptografia c69b_e9bb.
- N=32, M=4, T=44, ZSEL=3 (SIMON64/128):
  - key 1b1a1918_13121110_0b0a0908_03020100, texto 656b696c_20646e75 -> criptografia 44c8fc20_b9dfa07a;
  - then modo=1 with that ciphertext -> 656b696c_20646e75, without reloading the key.
- Backpressure: hold saida_pronta=0 for 10 cycles after saida_valida.
  - Output stays constant; bloco_pronto=0 and chave_pronta=0 throughout.
  - Release -> PRONTO on the next cycle.
- Reset mid-operation: assert rst during round 30 of a default-param block.
  - Next cycle: saida_valida=0, chave_carregada=0, chave_pronta=1, bloco_pronto=0.
  - A block offered afterwards is not accepted.
- Collision: in PRONTO, assert chave_valida and bloco_valido together.
  - Key is accepted, block is not; chave_carregada=0 for T-M cycles.
  - The block is accepted on the first PRONTO cycle afterwards and encrypts under the new key.
